// File: rtl/z80_bitop_pkg.sv
// Shared types and constants for the Z80 BIT/RES/SET memory-operand sequencer.
package z80_bitop_pkg;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_BIT  = 2'b01,
        OP_RES  = 2'b10,
        OP_SET  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        MODE_HL  = 2'b00,
        MODE_IX  = 2'b01,
        MODE_IY  = 2'b10,
        MODE_BAD = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        IDLE,
        EADDR,
        READ,
        MODIFY,
        WRITE,
        FINISH
    } state_e;

    localparam logic [4:0] TC_BIT_HL  = 5'd12;
    localparam logic [4:0] TC_RMW_HL  = 5'd15;
    localparam logic [4:0] TC_BIT_IDX = 5'd20;
    localparam logic [4:0] TC_RMW_IDX = 5'd23;

    localparam int FLAG_S  = 7;
    localparam int FLAG_Z  = 6;
    localparam int FLAG_Y  = 5;
    localparam int FLAG_H  = 4;
    localparam int FLAG_X  = 3;
    localparam int FLAG_PV = 2;
    localparam int FLAG_N  = 1;
    localparam int FLAG_C  = 0;

    function automatic logic [4:0] tcycles_for(input op_e op, input logic indexed);
        logic [4:0] tc;
        if (op == OP_BIT) tc = indexed ? TC_BIT_IDX : TC_BIT_HL;
        else              tc = indexed ? TC_RMW_IDX : TC_RMW_HL;
        return tc;
    endfunction

endpackage

// File: rtl/z80_bitop_alu.sv
// Combinational bit test/reset/set unit: produces the write-back byte and the BIT flags.
module z80_bitop_alu
    import z80_bitop_pkg::*;
(
    input  op_e         op,
    input  logic [2:0]  bitnum,
    input  logic [7:0]  data,
    input  logic [7:0]  f_in,
    input  logic [15:0] ea,
    input  logic        indexed,
    output logic [7:0]  wdata,
    output logic [7:0]  f_out
);

    logic unused_ea_bits;
    assign unused_ea_bits = ^{ea[15:14], ea[12], ea[10:0]};

    // Undocumented flag bits 5/3 leak the high address byte on indexed forms.
    always_comb begin
        wdata = data;
        f_out = f_in;
        case (op)
            OP_BIT: begin
                f_out[FLAG_S]  = (bitnum == 3'd7) & data[7];
                f_out[FLAG_Z]  = ~data[bitnum];
                f_out[FLAG_PV] = ~data[bitnum];
                f_out[FLAG_H]  = 1'b1;
                f_out[FLAG_N]  = 1'b0;
                if (indexed) begin
                    f_out[FLAG_Y] = ea[13];
                    f_out[FLAG_X] = ea[11];
                end
            end
            OP_RES:  wdata[bitnum] = 1'b0;
            OP_SET:  wdata[bitnum] = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/z80_bitop_mem_seq.sv
// Sequencer for BIT/RES/SET b,(HL)/(IX+d)/(IY+d): address calc, bus read,
// modify, bus write, with per-access wait timeout.
module z80_bitop_mem_seq
    import z80_bitop_pkg::*;
#(
    parameter bit INDEXED_EN = 1'b1,
    parameter int WAIT_MAX   = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [2:0]  bitnum,
    input  logic [1:0]  mode,
    input  logic [7:0]  disp,
    input  logic [15:0] hl,
    input  logic [15:0] ix,
    input  logic [15:0] iy,
    input  logic [7:0]  f_in,
    output logic        mem_rd_req,
    output logic        mem_wr_req,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  f_out,
    output logic [4:0]  tcycles
);

    localparam int WW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

    state_e        state, next_state;
    op_e           op_r;
    logic [2:0]    bitnum_r;
    logic          indexed_r;
    logic [7:0]    disp_r;
    logic [7:0]    f_in_r;
    logic [15:0]   ea_r;
    logic [7:0]    rdata_r;
    logic [7:0]    wdata_r;
    logic [7:0]    f_out_r;
    logic [4:0]    tcycles_r;
    logic [WW-1:0] wait_cnt;
    logic          err_r;

    logic          legal, accept, reject, timeout;
    logic [15:0]   base_sel;
    logic [7:0]    alu_wdata, alu_f_out;

    assign legal   = (op != OP_NONE) && (mode != MODE_BAD) && (INDEXED_EN || mode == MODE_HL);
    assign accept  = (state == IDLE) && start && legal;
    assign reject  = (state == IDLE) && start && !legal;
    assign timeout = !mem_ack && (wait_cnt == WW'(WAIT_MAX - 1));

    always_comb begin
        base_sel = hl;
        case (mode)
            MODE_IX: base_sel = ix;
            MODE_IY: base_sel = iy;
            default: base_sel = hl;
        endcase
    end

    z80_bitop_alu u_alu (
        .op      (op_r),
        .bitnum  (bitnum_r),
        .data    (rdata_r),
        .f_in    (f_in_r),
        .ea      (ea_r),
        .indexed (indexed_r),
        .wdata   (alu_wdata),
        .f_out   (alu_f_out)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        mem_rd_req = 1'b0;
        mem_wr_req = 1'b0;
        case (state)
            IDLE: begin
                if (accept) next_state = (mode != MODE_HL) ? EADDR : READ;
            end
            EADDR: begin
                busy       = 1'b1;
                next_state = READ;
            end
            READ: begin
                busy       = 1'b1;
                mem_rd_req = 1'b1;
                if (mem_ack)      next_state = MODIFY;
                else if (timeout) next_state = IDLE;
            end
            MODIFY: begin
                busy       = 1'b1;
                next_state = (op_r == OP_BIT) ? FINISH : WRITE;
            end
            WRITE: begin
                busy       = 1'b1;
                mem_wr_req = 1'b1;
                if (mem_ack)      next_state = FINISH;
                else if (timeout) next_state = IDLE;
            end
            FINISH: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // f_out only moves on a completed instruction, so aborts leave it untouched.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            op_r      <= OP_NONE;
            bitnum_r  <= '0;
            indexed_r <= 1'b0;
            disp_r    <= '0;
            f_in_r    <= '0;
            ea_r      <= '0;
            rdata_r   <= '0;
            wdata_r   <= '0;
            f_out_r   <= '0;
            tcycles_r <= '0;
            wait_cnt  <= '0;
            err_r     <= 1'b0;
        end else begin
            err_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_r      <= op_e'(op);
                        bitnum_r  <= bitnum;
                        indexed_r <= (mode != MODE_HL);
                        disp_r    <= disp;
                        f_in_r    <= f_in;
                        ea_r      <= base_sel;
                        tcycles_r <= tcycles_for(op_e'(op), mode != MODE_HL);
                        wait_cnt  <= '0;
                    end else if (reject) begin
                        err_r <= 1'b1;
                    end
                end
                EADDR: begin
                    ea_r     <= ea_r + {{8{disp_r[7]}}, disp_r};
                    wait_cnt <= '0;
                end
                READ: begin
                    if (mem_ack) begin
                        rdata_r  <= mem_rdata;
                        wait_cnt <= '0;
                    end else if (timeout) begin
                        err_r    <= 1'b1;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                MODIFY: begin
                    wait_cnt <= '0;
                    if (op_r == OP_BIT) f_out_r <= alu_f_out;
                    else                wdata_r <= alu_wdata;
                end
                WRITE: begin
                    if (mem_ack) begin
                        f_out_r  <= f_in_r;
                        wait_cnt <= '0;
                    end else if (timeout) begin
                        err_r    <= 1'b1;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_addr  = ea_r;
    assign mem_wdata = wdata_r;
    assign f_out     = f_out_r;
    assign tcycles   = tcycles_r;
    assign err       = err_r;

endmodule

// File: tb/tb_z80_bitop_mem_seq.sv
// Scoreboard bench for z80_bitop_mem_seq with a behavioural memory responder.
module tb_z80_bitop_mem_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = '0;
    logic [2:0]  bitnum = '0;
    logic [1:0]  mode = '0;
    logic [7:0]  disp = '0;
    logic [15:0] hl = '0, ix = '0, iy = '0;
    logic [7:0]  f_in = '0;
    logic        mem_rd_req, mem_wr_req;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        busy, done, err;
    logic [7:0]  f_out;
    logic [4:0]  tcycles;

    typedef struct {
        bit          is_err;
        logic [7:0]  fout;
        logic [4:0]  tc;
        bit          has_wr;
        logic [15:0] ea;
        logic [7:0]  wdata;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  mem [0:65535];
    int          errors = 0;
    int          checks = 0;
    int          rd_wait = 0, wr_wait = 0;
    bit          rd_noack = 1'b0;
    int          req_cnt = 0;
    int          wr_count = 0, exp_wr_total = 0;
    int          rd_req_cycles = 0;
    int          excl_viol = 0;
    logic [15:0] last_rd_addr = '0, last_wr_addr = '0;
    logic [7:0]  last_wr_data = '0;
    logic [7:0]  hold_fout = '0;
    logic [4:0]  hold_tc = '0;

    z80_bitop_mem_seq dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .op         (op),
        .bitnum     (bitnum),
        .mode       (mode),
        .disp       (disp),
        .hl         (hl),
        .ix         (ix),
        .iy         (iy),
        .f_in       (f_in),
        .mem_rd_req (mem_rd_req),
        .mem_wr_req (mem_wr_req),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .f_out      (f_out),
        .tcycles    (tcycles)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Memory responder: acks after a programmable number of wait cycles.
    always @(negedge clk) begin
        if (mem_rd_req && mem_wr_req) excl_viol++;
        if (mem_rd_req) rd_req_cycles++;
        if (mem_rd_req || mem_wr_req) begin
            if (!(mem_rd_req && rd_noack) && req_cnt == (mem_rd_req ? rd_wait : wr_wait)) begin
                mem_ack = 1'b1;
                if (mem_rd_req) begin
                    mem_rdata    = mem[mem_addr];
                    last_rd_addr = mem_addr;
                end else begin
                    mem[mem_addr] = mem_wdata;
                    wr_count++;
                    last_wr_addr  = mem_addr;
                    last_wr_data  = mem_wdata;
                end
                req_cnt = 0;
            end else begin
                mem_ack = 1'b0;
                req_cnt++;
            end
        end else begin
            mem_ack = 1'b0;
            req_cnt = 0;
        end
    end

    // Output monitor: every done/err pops one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && (done || err)) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_event", {30'd0, done, err}, 32'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("event_is_err", {31'd0, err}, {31'd0, e.is_err});
                checkOutput("f_out", {24'd0, f_out}, {24'd0, e.fout});
                checkOutput("tcycles", {27'd0, tcycles}, {27'd0, e.tc});
                if (!e.is_err) begin
                    checkOutput("rd_addr", {16'd0, last_rd_addr}, {16'd0, e.ea});
                    checkOutput("wr_count", wr_count, exp_wr_total);
                    if (e.has_wr) begin
                        checkOutput("wr_addr", {16'd0, last_wr_addr}, {16'd0, e.ea});
                        checkOutput("wr_data", {24'd0, last_wr_data}, {24'd0, e.wdata});
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input logic [1:0] op_i, input logic [2:0] b_i, input logic [1:0] mode_i,
                                 input logic [7:0] disp_i, input logic [15:0] hl_i, input logic [15:0] ix_i,
                                 input logic [15:0] iy_i, input logic [7:0] f_i, input logic [7:0] data_i,
                                 input bit exp_timeout);
        exp_t        e;
        logic [15:0] base;
        logic [7:0]  d;
        bit          idx;
        @(negedge clk);
        start = 1'b1; op = op_i; bitnum = b_i; mode = mode_i; disp = disp_i;
        hl = hl_i; ix = ix_i; iy = iy_i; f_in = f_i;
        e.has_wr = 1'b0; e.wdata = '0; e.ea = '0;
        if (op_i == 2'b00 || mode_i == 2'b11) begin
            e.is_err = 1'b1; e.fout = hold_fout; e.tc = hold_tc;
        end else begin
            idx  = (mode_i != 2'b00);
            base = (mode_i == 2'b01) ? ix_i : (mode_i == 2'b10) ? iy_i : hl_i;
            e.ea = idx ? base + {{8{disp_i[7]}}, disp_i} : base;
            mem[e.ea] = data_i;
            d = data_i;
            e.tc = (op_i == 2'b01) ? 5'd12 : 5'd15;
            if (idx) e.tc = e.tc + 5'd8;
            hold_tc = e.tc;
            if (exp_timeout) begin
                e.is_err = 1'b1; e.fout = hold_fout;
            end else begin
                e.is_err = 1'b0;
                if (op_i == 2'b01) begin
                    e.fout = {(b_i == 3'd7) && d[7], ~d[b_i], idx ? e.ea[13] : f_i[5], 1'b1,
                              idx ? e.ea[11] : f_i[3], ~d[b_i], 1'b0, f_i[0]};
                end else begin
                    e.fout   = f_i;
                    e.has_wr = 1'b1;
                    e.wdata  = (op_i == 2'b10) ? (d & ~(8'h01 << b_i)) : (d | (8'h01 << b_i));
                    exp_wr_total++;
                end
                hold_fout = e.fout;
            end
        end
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        checkOutput("drain", sb.size(), 0);
        sb.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic checkQuiet(input string tag);
        for (int i = 0; i < 3; i++) begin
            checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
            checkOutput({tag, "_req"}, {30'd0, mem_rd_req, mem_wr_req}, 32'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int wr_before;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_err", {31'd0, err}, 32'd0);
        checkOutput("rst_req", {30'd0, mem_rd_req, mem_wr_req}, 32'd0);
        checkOutput("rst_addr", {16'd0, mem_addr}, 32'd0);
        checkOutput("rst_wdata", {24'd0, mem_wdata}, 32'd0);
        checkOutput("rst_fout", {24'd0, f_out}, 32'd0);
        checkOutput("rst_tc", {27'd0, tcycles}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        $display("[TB] BIT 7,(HL)");
        applyStimulus(2'b01, 3'd7, 2'b00, 8'h00, 16'h4000, 16'h0, 16'h0, 8'h00, 8'h80, 1'b0);
        waitIdle();
        checkOutput("bit7_fout", {24'd0, f_out}, 32'h90);

        $display("[TB] SET 0,(IX+1) wrap");
        applyStimulus(2'b11, 3'd0, 2'b01, 8'h01, 16'h1234, 16'hFFFF, 16'h0, 8'h5A, 8'hFE, 1'b0);
        waitIdle();
        checkOutput("set_mem0000", {24'd0, mem[16'h0000]}, 32'hFF);

        $display("[TB] RES 3,(IY-128) with write waits");
        wr_wait = 3;
        applyStimulus(2'b10, 3'd3, 2'b10, 8'h80, 16'h0, 16'h0, 16'h1000, 8'hC3, 8'h0F, 1'b0);
        waitIdle();
        checkOutput("res_mem0F80", {24'd0, mem[16'h0F80]}, 32'h07);
        wr_wait = 0;

        $display("[TB] BIT indexed / HL flag sources");
        applyStimulus(2'b01, 3'd0, 2'b01, 8'h7F, 16'h0, 16'h2000, 16'h0, 8'h29, 8'h01, 1'b0);
        waitIdle();
        applyStimulus(2'b01, 3'd3, 2'b00, 8'h00, 16'h0800, 16'h0, 16'h0, 8'hFF, 8'h00, 1'b0);
        waitIdle();
        checkOutput("bit3_fout", {24'd0, f_out}, 32'h7D);

        $display("[TB] illegal requests");
        applyStimulus(2'b00, 3'd1, 2'b00, 8'h00, 16'h0100, 16'h0, 16'h0, 8'h00, 8'h00, 1'b0);
        checkQuiet("ill_op");
        waitIdle();
        applyStimulus(2'b01, 3'd1, 2'b11, 8'h00, 16'h0100, 16'h0, 16'h0, 8'h00, 8'h00, 1'b0);
        checkQuiet("ill_mode");
        waitIdle();

        $display("[TB] start while busy");
        rd_wait = 4;
        applyStimulus(2'b10, 3'd5, 2'b00, 8'h00, 16'h5000, 16'h0, 16'h0, 8'h11, 8'hFF, 1'b0);
        start = 1'b1; op = 2'b11; bitnum = 3'd1; hl = 16'h6000; f_in = 8'hEE;
        repeat (2) @(negedge clk);
        start = 1'b0;
        waitIdle();
        rd_wait = 0;
        checkOutput("busy_ignored_mem", {24'd0, mem[16'h5000]}, 32'hDF);

        $display("[TB] read timeout");
        rd_noack = 1'b1;
        rd_req_cycles = 0;
        applyStimulus(2'b01, 3'd2, 2'b00, 8'h00, 16'h7000, 16'h0, 16'h0, 8'hAA, 8'h04, 1'b1);
        waitIdle();
        checkOutput("timeout_req_cycles", rd_req_cycles, 15);
        rd_noack = 1'b0;

        $display("[TB] random operations");
        for (int n = 0; n < 10; n++) begin
            rd_wait = $urandom_range(0, 4);
            wr_wait = $urandom_range(0, 4);
            applyStimulus(2'($urandom_range(1, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 2)),
                          8'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 8'($urandom),
                          8'($urandom), 1'b0);
            waitIdle();
        end
        rd_wait = 0; wr_wait = 0;

        $display("[TB] reset during write");
        wr_wait = 10;
        wr_before = wr_count;
        applyStimulus(2'b10, 3'd6, 2'b00, 8'h00, 16'h3000, 16'h0, 16'h0, 8'h00, 8'hFF, 1'b0);
        for (int i = 0; i < 20 && !mem_wr_req; i++) @(negedge clk);
        checkOutput("wr_req_seen", {31'd0, mem_wr_req}, 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        checkOutput("rstw_req", {30'd0, mem_rd_req, mem_wr_req}, 32'd0);
        checkOutput("rstw_busy", {31'd0, busy}, 32'd0);
        checkOutput("rstw_done", {31'd0, done}, 32'd0);
        checkOutput("rstw_addr", {16'd0, mem_addr}, 32'd0);
        checkOutput("rstw_tc", {27'd0, tcycles}, 32'd0);
        reset_n = 1'b1;
        sb.delete();
        exp_wr_total--;
        hold_fout = '0; hold_tc = '0;
        wr_wait = 0;
        repeat (20) @(negedge clk);
        checkOutput("rstw_no_rewrite", wr_count, wr_before);
        checkOutput("rstw_mem", {24'd0, mem[16'h3000]}, 32'hFF);

        $display("[TB] operation after reset");
        applyStimulus(2'b11, 3'd4, 2'b00, 8'h00, 16'h3000, 16'h0, 16'h0, 8'h42, 8'h00, 1'b0);
        waitIdle();
        checkOutput("excl_req", excl_viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/z80_bitop_mem_seq.md
Z80_BITOP_MEM_SEQ -- requirements
Module: z80_bitop_mem_seq

Interface
REQ-001 Parameter INDEXED_EN, default 1: 1 enables the (IX+d)/(IY+d) modes; 0 treats them as illegal.
REQ-002 Parameter WAIT_MAX, default 15: maximum bus wait cycles per access before a timeout abort.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset_n  in  1  reset, synchronous and active-low.
REQ-005 start  in  1  request pulse; accepted only when busy=0.
REQ-006 op  in  2  operation: 01=BIT, 10=RES, 11=SET; 00 is illegal.
REQ-007 bitnum  in  3  bit index b.
REQ-008 mode  in  2  addressing: 00=(HL), 01=(IX+d), 10=(IY+d); 11 is illegal.
REQ-009 disp  in  8  displacement d, two's complement.
REQ-010 hl, ix, iy  in  16 each  register values, sampled at start.
REQ-011 f_in  in  8  flag register, sampled at start.
REQ-012 mem_rd_req, mem_wr_req  out  1 each  bus requests; never both high.
REQ-013 mem_addr  out  16  effective address.
REQ-014 mem_wdata  out  8  write data.
REQ-015 mem_rdata  in  8  read data, valid on a cycle where mem_ack=1.
REQ-016 mem_ack  in  1  completes the pending request.
REQ-017 busy  out  1  high from the accept cycle until done or abort.
REQ-018 done  out  1  one-cycle completion pulse.
REQ-019 err  out  1  one-cycle pulse on illegal-request reject or timeout abort.
REQ-020 f_out  out  8  resulting flags, held until the next accept.
REQ-021 tcycles  out  5  Z80 T-state total for the accepted instruction.

Function
REQ-022 FSM states: IDLE, EADDR, READ, MODIFY, WRITE, FINISH.
REQ-023 IDLE + start with a legal request -> latch all inputs; assert busy; go to EADDR for an indexed mode, otherwise READ.
REQ-024 Illegal request (op=00, mode=11, or indexed with INDEXED_EN=0) -> err pulse next cycle; stay IDLE; busy stays 0.
REQ-025 EADDR lasts exactly 1 cycle: ea = base + sign_extend(disp), modulo 2^16 (wraps, e.g. FFFF+01=0000).
REQ-026 READ: mem_rd_req=1 and mem_addr=ea until mem_ack; capture mem_rdata on the ack cycle, then MODIFY.
REQ-027 MODIFY, 1 cycle: BIT -> FINISH; RES/SET -> compute wdata = rdata with bit b cleared/set, then WRITE.
REQ-028 WRITE: mem_wr_req=1, mem_addr=ea, mem_wdata stable until mem_ack, then FINISH.
REQ-029 FINISH: done=1 for one cycle; busy falls in the same cycle; next state IDLE; a start in this cycle is ignored.
REQ-030 start while busy=1 is ignored, with no side effects.
REQ-031 BIT flag rules:
  - S = (b==7) & rdata[7]
  - Z = P/V = ~rdata[b]
  - H = 1, N = 0, C = f_in.C
  - bits 5/3: from f_in for (HL); from ea[13]/ea[11] for indexed modes.
REQ-032 RES/SET: f_out = f_in unchanged.
REQ-033 tcycles: BIT(HL)=12, RES/SET(HL)=15, BIT indexed=20, RES/SET indexed=23; latched at accept.
REQ-034 Wait timeout: a wait counter clears at the start of each access and increments per unacked cycle. When it reaches WAIT_MAX, drop the request, pulse err, return to IDLE, no done, f_out unchanged.
REQ-035 mem_ack outside READ/WRITE is ignored.

Reset
REQ-036 reset_n=0 at a clock edge forces state IDLE, including mid-operation. The same edge clears busy, done, err, mem_rd_req, mem_wr_req and the wait counter; mem_addr, mem_wdata, f_out and tcycles all go to 0.
REQ-037 A write interrupted by reset is not re-issued after reset.

Structure
REQ-038 Shared package z80_bitop_pkg holds: the op and mode enums, the FSM state enum, the tcycle constants, and the flag bit-position constants.
REQ-039 One combinational sub-module, z80_bitop_alu (op, bitnum, data, f_in, ea, indexed -> wdata, f_out), instanced once.

Verification
REQ-040 BIT 7,(HL), hl=4000, mem[4000]=80, f_in=00, ack at once -> F=90 (S=1, Z=0, H=1), tcycles=12, no write, done.
REQ-041 SET 0,(IX+d), ix=FFFF, disp=01, mem[0000]=FE -> read and write at 0000, wdata=FF, f_out=f_in, tcycles=23.
REQ-042 RES 3,(IY+d), iy=1000, disp=80, mem[0F80]=0F, write ack after 3 waits -> wdata=07, done after the ack.
REQ-043 BIT with op=00 or mode=11 -> err pulse, busy stays 0, no bus request; start while busy -> ignored.
REQ-044 No ack for WAIT_MAX cycles -> err pulse, request dropped, IDLE, no done.
REQ-045 reset_n=0 during WRITE with req high -> req low at the next edge, IDLE, no done, no further writes.
